// File: rtl/idct_pkg.sv
// Shared constants for the 8-point inverse DCT.
//   - default widths for coefficients, cosine constants, output samples
//   - accumulator sizing (product width plus 3 guard bits for 8 terms)
//   - FSM state encoding
//   - 64-entry cosine table, index {n[2:0],k[2:0]}:
//     C[n][k] = round(2^14 * c(k) * cos((2n+1)k*pi/16))
package idct_pkg;

  localparam int COEF_W    = 19;
  localparam int ROM_W     = 16;
  localparam int FRAC_W    = 14;
  localparam int OUT_SHIFT = 0;
  localparam int OUT_W     = 8;
  // 8 accumulated terms need 3 bits above the product width
  localparam int ACC_GUARD = 3;
  localparam int ACC_W     = COEF_W + ROM_W + ACC_GUARD;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic signed [ROM_W-1:0] COS_TBL [64] = '{
    // n = 0
    16'sd5793,  16'sd8035,  16'sd7568,  16'sd6811,
    16'sd5793,  16'sd4551,  16'sd3135,  16'sd1598,
    // n = 1
    16'sd5793,  16'sd6811,  16'sd3135, -16'sd1598,
   -16'sd5793, -16'sd8035, -16'sd7568, -16'sd4551,
    // n = 2
    16'sd5793,  16'sd4551, -16'sd3135, -16'sd8035,
   -16'sd5793,  16'sd1598,  16'sd7568,  16'sd6811,
    // n = 3
    16'sd5793,  16'sd1598, -16'sd7568, -16'sd4551,
    16'sd5793,  16'sd6811, -16'sd3135, -16'sd8035,
    // n = 4
    16'sd5793, -16'sd1598, -16'sd7568,  16'sd4551,
    16'sd5793, -16'sd6811, -16'sd3135,  16'sd8035,
    // n = 5
    16'sd5793, -16'sd4551, -16'sd3135,  16'sd8035,
   -16'sd5793, -16'sd1598,  16'sd7568, -16'sd6811,
    // n = 6
    16'sd5793, -16'sd6811,  16'sd3135,  16'sd1598,
   -16'sd5793,  16'sd8035, -16'sd7568,  16'sd4551,
    // n = 7
    16'sd5793, -16'sd8035,  16'sd7568, -16'sd6811,
    16'sd5793, -16'sd4551,  16'sd3135, -16'sd1598
  };

endpackage

// File: rtl/idct_cos_rom.sv
// Combinational cosine constant lookup.
//   addr : {n[2:0], k[2:0]}
//   coef : signed Q1.(ROM_W-2) constant C[n][k]
module idct_cos_rom #(
  parameter int ROM_W = idct_pkg::ROM_W
) (
  input  logic [5:0]              addr,
  output logic signed [ROM_W-1:0] coef
);
  import idct_pkg::*;

  assign coef = ROM_W'(COS_TBL[addr]);

endmodule

// File: rtl/idct_module.sv
// 8-point inverse DCT, one shared MAC.
// Loads X[0..7] over a valid/ready input stream, then for each n computes
// sum_k X[k]*C[n][k] in 8 cycles, rounds half-up, saturates and presents
// x[n] on a valid/ready output stream (out_last with x[7]).
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : coefficient handshake, in_data = X[k]
//   out_valid/out_ready  : sample handshake, out_data = x[n], out_last
module idct_module #(
  parameter int COEF_W    = idct_pkg::COEF_W,
  parameter int ROM_W     = idct_pkg::ROM_W,
  parameter int FRAC_W    = idct_pkg::FRAC_W,
  parameter int OUT_SHIFT = idct_pkg::OUT_SHIFT,
  parameter int OUT_W     = idct_pkg::OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last
);
  import idct_pkg::*;

  localparam int PROD_W = COEF_W + ROM_W;
  localparam int ACC_W  = PROD_W + ACC_GUARD;
  localparam int SH     = FRAC_W + OUT_SHIFT;

  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(64'd1 << (SH - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2**(OUT_W-1)));

  state_t state, state_nxt;

  logic [2:0]               k, n;
  logic [7:0][COEF_W-1:0]   cbuf;
  logic signed [ACC_W-1:0]  acc, acc_nxt, rsh;
  logic signed [COEF_W-1:0] cdat;
  logic signed [ROM_W-1:0]  coef;
  logic signed [PROD_W-1:0] prod;
  logic [OUT_W-1:0]         sat;

  idct_cos_rom #(.ROM_W(ROM_W)) u_rom (
    .addr ({n, k}),
    .coef (coef)
  );

  // MAC datapath
  assign cdat    = cbuf[k];
  assign prod    = PROD_W'(cdat) * PROD_W'(coef);
  assign acc_nxt = acc + ACC_W'(prod);

  // Round/saturate works on acc_nxt so the k=7 term is included in the
  // value registered as the MAC->OUT transition happens.
  assign rsh = (acc_nxt + RND) >>> SH;

  always_comb begin
    if (rsh > SAT_HI)      sat = SAT_HI[OUT_W-1:0];
    else if (rsh < SAT_LO) sat = SAT_LO[OUT_W-1:0];
    else                   sat = rsh[OUT_W-1:0];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_valid && k == 3'd7) state_nxt = MAC;
      MAC:     if (k == 3'd7)             state_nxt = OUT;
      OUT:     if (out_ready)             state_nxt = (n == 3'd7) ? LOAD : MAC;
      default:                            state_nxt = LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == OUT);
  end

  // Counters, buffer, accumulator, output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      n        <= '0;
      acc      <= '0;
      cbuf     <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            cbuf[k] <= in_data;
            k       <= k + 3'd1;     // wraps to 0 after X[7]
            if (k == 3'd7) begin
              n   <= '0;
              acc <= '0;
            end
          end
        end
        MAC: begin
          acc <= acc_nxt;
          k   <= k + 3'd1;
          if (k == 3'd7) begin
            out_data <= sat;
            out_last <= (n == 3'd7);
          end
        end
        OUT: begin
          if (out_ready) begin
            k   <= '0;
            acc <= '0;
            n   <= n + 3'd1;         // wraps to 0 after x[7]
          end
        end
        default: ;
      endcase
    end
  end

endmodule
